cv32e40p_rf_recovery: RTL and testbench

Shadow register-file and replay controller on the other end of the core's RF recovery interface. It captures every committed register-file write the core reports on its RF write outputs (ports A/B) into a shadow copy. On a recovery request it takes over the core's RF write ports and replays the full shadow contents, two registers per cycle. It is instantiated next to cv32e40p_core in fault-tolerant wrappers and is driven by the lockstep/error-detection logic.

---
 rtl/cv32e40p_pkg.sv | 12 +
 rtl/cv32e40p_rf_shadow.sv | 42 ++++
 rtl/cv32e40p_rf_recovery.sv | 107 ++++++++++
 tb/tb_cv32e40p_rf_recovery.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: shared types and constants for the RF recovery slice
package cv32e40p_pkg;

    localparam int RF_ADDR_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE,
        REPLAY,
        DONE
    } rf_rec_state_e;

endpackage

// File: rtl/cv32e40p_rf_shadow.sv
// cv32e40p_rf_shadow: flop-based shadow register file, 2 gated write ports (B wins, x0 masked), 2 read ports
module cv32e40p_rf_shadow
    import cv32e40p_pkg::*;
#(
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    localparam int IW        = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_wr_en,
    input  logic                  i_we_a,
    input  logic [ADDR_WIDTH-1:0] i_waddr_a,
    input  logic [31:0]           i_wdata_a,
    input  logic                  i_we_b,
    input  logic [ADDR_WIDTH-1:0] i_waddr_b,
    input  logic [31:0]           i_wdata_b,
    input  logic [IW-1:0]         i_raddr_a,
    output logic [31:0]           o_rdata_a,
    input  logic [IW-1:0]         i_raddr_b,
    output logic [31:0]           o_rdata_b
);

    logic [31:0] r_mem [NUM_WORDS];

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        logic w_hit_a;
        logic w_hit_b;
        assign w_hit_a = i_wr_en && i_we_a && (i_waddr_a == ADDR_WIDTH'(g)) && (i_waddr_a != '0);
        assign w_hit_b = i_wr_en && i_we_b && (i_waddr_b == ADDR_WIDTH'(g)) && (i_waddr_b != '0);
        // per-word update; port B overrides port A on the same address
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_mem[g] <= '0;
            else if (w_hit_b) r_mem[g] <= i_wdata_b;
            else if (w_hit_a) r_mem[g] <= i_wdata_a;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cv32e40p_rf_recovery.sv
// cv32e40p_rf_recovery: shadows committed RF writes and replays them into the core on request
module cv32e40p_rf_recovery
    import cv32e40p_pkg::*;
#(
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  capture_en_i,
    input  logic                  core_we_a_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_a_i,
    input  logic [31:0]           core_wdata_a_i,
    input  logic                  core_we_b_i,
    input  logic [ADDR_WIDTH-1:0] core_waddr_b_i,
    input  logic [31:0]           core_wdata_b_i,
    input  logic                  recovery_req_i,
    output logic                  recover_o,
    output logic                  rec_we_a_o,
    output logic [ADDR_WIDTH-1:0] rec_waddr_a_o,
    output logic [31:0]           rec_wdata_a_o,
    output logic                  rec_we_b_o,
    output logic [ADDR_WIDTH-1:0] rec_waddr_b_o,
    output logic [31:0]           rec_wdata_b_o,
    output logic                  recovery_busy_o,
    output logic                  recovery_done_o
);

    localparam int IW = $clog2(NUM_WORDS);
    localparam int CW = IW - 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS / 2 - 1);

    rf_rec_state_e r_state;
    rf_rec_state_e w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic          w_replay;
    logic [IW-1:0] w_raddr_a;
    logic [IW-1:0] w_raddr_b;
    logic [31:0]   w_rdata_a;
    logic [31:0]   w_rdata_b;

    assign w_replay  = (r_state == REPLAY);
    assign w_raddr_a = {r_cnt, 1'b0};
    assign w_raddr_b = {r_cnt, 1'b1};

    cv32e40p_rf_shadow #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_shadow (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_wr_en  (capture_en_i && (r_state == IDLE)),
        .i_we_a   (core_we_a_i),
        .i_waddr_a(core_waddr_a_i),
        .i_wdata_a(core_wdata_a_i),
        .i_we_b   (core_we_b_i),
        .i_waddr_b(core_waddr_b_i),
        .i_wdata_b(core_wdata_b_i),
        .i_raddr_a(w_raddr_a),
        .o_rdata_a(w_rdata_a),
        .i_raddr_b(w_raddr_b),
        .o_rdata_b(w_rdata_b)
    );

    // state and replay counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // next state: IDLE waits for a request, REPLAY walks word pairs, DONE lasts one cycle
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            IDLE: begin
                w_state_n = recovery_req_i ? REPLAY : IDLE;
                w_cnt_n   = '0;
            end
            REPLAY: begin
                w_state_n = (r_cnt == LAST) ? DONE : REPLAY;
                w_cnt_n   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign recover_o       = w_replay;
    assign rec_we_a_o      = w_replay && (r_cnt != '0);
    assign rec_we_b_o      = w_replay;
    assign rec_waddr_a_o   = w_replay ? ADDR_WIDTH'(w_raddr_a) : '0;
    assign rec_waddr_b_o   = w_replay ? ADDR_WIDTH'(w_raddr_b) : '0;
    assign rec_wdata_a_o   = w_replay ? w_rdata_a : '0;
    assign rec_wdata_b_o   = w_replay ? w_rdata_b : '0;
    assign recovery_busy_o = (r_state != IDLE);
    assign recovery_done_o = (r_state == DONE);

endmodule

// File: tb/tb_cv32e40p_rf_recovery.sv
// tb_cv32e40p_rf_recovery: scoreboard bench for the RF shadow/replay controller
module tb_cv32e40p_rf_recovery;

    typedef struct packed {
        logic        we_a;
        logic [5:0]  addr_a;
        logic [31:0] data_a;
        logic        we_b;
        logic [5:0]  addr_b;
        logic [31:0] data_b;
        logic        rec;
        logic        done;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        capture_en_i = 1'b0;
    logic        core_we_a_i = 1'b0;
    logic [5:0]  core_waddr_a_i = '0;
    logic [31:0] core_wdata_a_i = '0;
    logic        core_we_b_i = 1'b0;
    logic [5:0]  core_waddr_b_i = '0;
    logic [31:0] core_wdata_b_i = '0;
    logic        recovery_req_i = 1'b0;
    logic        recover_o;
    logic        rec_we_a_o;
    logic [5:0]  rec_waddr_a_o;
    logic [31:0] rec_wdata_a_o;
    logic        rec_we_b_o;
    logic [5:0]  rec_waddr_b_o;
    logic [31:0] rec_wdata_b_o;
    logic        recovery_busy_o;
    logic        recovery_done_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int req_cyc = 0;
    int last_done_cyc = -100;
    logic prev_rec = 1'b0;
    logic [31:0] m [64];
    obs_t q [$];

    cv32e40p_rf_recovery dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .capture_en_i   (capture_en_i),
        .core_we_a_i    (core_we_a_i),
        .core_waddr_a_i (core_waddr_a_i),
        .core_wdata_a_i (core_wdata_a_i),
        .core_we_b_i    (core_we_b_i),
        .core_waddr_b_i (core_waddr_b_i),
        .core_wdata_b_i (core_wdata_b_i),
        .recovery_req_i (recovery_req_i),
        .recover_o      (recover_o),
        .rec_we_a_o     (rec_we_a_o),
        .rec_waddr_a_o  (rec_waddr_a_o),
        .rec_wdata_a_o  (rec_wdata_a_o),
        .rec_we_b_o     (rec_we_b_o),
        .rec_waddr_b_o  (rec_waddr_b_o),
        .rec_wdata_b_o  (rec_wdata_b_o),
        .recovery_busy_o(recovery_busy_o),
        .recovery_done_o(recovery_done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t observed();
        return '{rec_we_a_o, rec_waddr_a_o, rec_wdata_a_o, rec_we_b_o, rec_waddr_b_o,
                 rec_wdata_b_o, recover_o, recovery_done_o, recovery_busy_o};
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops one expected entry whenever the DUT shows replay or done activity
    always @(negedge clk) begin
        obs_t o;
        obs_t e;
        o = observed();
        if (recover_o && !prev_rec) begin
            if (last_done_cyc > req_cyc) chk("b2b_gap", 96'(cyc - last_done_cyc), 96'd2);
            else chk("req_latency", 96'(cyc - req_cyc), 96'd1);
        end
        prev_rec = recover_o;
        if (recover_o || recovery_done_o) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 96'(o), 96'(0));
            end else begin
                e = q.pop_front();
                chk(e.done ? "done_cycle" : $sformatf("replay_cnt%0d", e.addr_b >> 1), 96'(o), 96'(e));
                if (recovery_done_o) last_done_cyc = cyc;
            end
        end else begin
            chk("idle_outputs", 96'(o), 96'(0));
        end
    end

    function automatic void mdl(input logic en, input logic we, input logic [5:0] a, input logic [31:0] d);
        if (en && we && a != 6'd0) m[a] = d;
    endfunction

    task automatic drive_cap(input logic en, input logic wea, input logic [5:0] aa, input logic [31:0] da,
                             input logic web, input logic [5:0] ab, input logic [31:0] db);
        capture_en_i = en;
        core_we_a_i = wea;
        core_waddr_a_i = aa;
        core_wdata_a_i = da;
        core_we_b_i = web;
        core_waddr_b_i = ab;
        core_wdata_b_i = db;
        mdl(en, wea, aa, da);
        mdl(en, web, ab, db);
    endtask

    task automatic clr_cap();
        capture_en_i = 1'b0;
        core_we_a_i = 1'b0;
        core_we_b_i = 1'b0;
        core_waddr_a_i = '0;
        core_waddr_b_i = '0;
        core_wdata_a_i = '0;
        core_wdata_b_i = '0;
    endtask

    task automatic push_replay();
        for (int k = 0; k < 32; k++)
            q.push_back('{k != 0, 6'(2 * k), m[2 * k], 1'b1, 6'(2 * k + 1), m[2 * k + 1], 1'b1, 1'b0, 1'b1});
        q.push_back('{1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, 1'b1});
    endtask

    task automatic wait_q(input string name, input int lvl);
        for (int i = 0; i < 80 && q.size() > lvl; i++) @(posedge clk);
        if (q.size() > lvl) begin
            chk({name, "_timeout"}, 96'(q.size()), 96'(lvl));
            q.delete();
        end
    endtask

    // caller is aligned just after a posedge; any capture set up beforehand lands in the request cycle
    task automatic start_replay(input string name);
        recovery_req_i = 1'b1;
        req_cyc = cyc;
        push_replay();
        @(posedge clk);
        #1;
        recovery_req_i = 1'b0;
        clr_cap();
        wait_q(name, 0);
    endtask

    task automatic cap_cycle(input logic en, input logic wea, input logic [5:0] aa, input logic [31:0] da,
                             input logic web, input logic [5:0] ab, input logic [31:0] db);
        @(posedge clk);
        #1;
        drive_cap(en, wea, aa, da, web, ab, db);
        @(posedge clk);
        #1;
        clr_cap();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 96'(observed()), 96'(0));
        rst_ni = 1'b1;

        // zero shadow after reset
        @(posedge clk);
        #1;
        start_replay("zeros");

        // single captures on A and B
        cap_cycle(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'h0);
        cap_cycle(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 6'd37, 32'h12345678);
        @(posedge clk);
        #1;
        start_replay("capture_ab");

        // same-address conflict and an x0 write
        cap_cycle(1'b1, 1'b1, 6'd10, 32'h1, 1'b1, 6'd10, 32'h2);
        cap_cycle(1'b1, 1'b1, 6'd0, 32'hFFFF, 1'b0, 6'd0, 32'h0);
        @(posedge clk);
        #1;
        start_replay("conflict");

        // gated capture, then capture in the request cycle
        cap_cycle(1'b0, 1'b1, 6'd3, 32'hAA, 1'b0, 6'd0, 32'h0);
        @(posedge clk);
        #1;
        start_replay("gated");
        @(posedge clk);
        #1;
        drive_cap(1'b1, 1'b1, 6'd3, 32'hAA, 1'b1, 6'd62, 32'hCAFE0062);
        start_replay("req_cycle_capture");

        // writes during replay are ignored
        @(posedge clk);
        #1;
        recovery_req_i = 1'b1;
        req_cyc = cyc;
        push_replay();
        @(posedge clk);
        #1;
        recovery_req_i = 1'b0;
        capture_en_i = 1'b1;
        core_we_a_i = 1'b1;
        core_waddr_a_i = 6'd7;
        core_wdata_a_i = 32'h55;
        core_we_b_i = 1'b1;
        core_waddr_b_i = 6'd5;
        core_wdata_b_i = 32'h77;
        wait_q("frozen", 0);
        clr_cap();

        // request held high across two replays
        @(posedge clk);
        #1;
        recovery_req_i = 1'b1;
        req_cyc = cyc;
        push_replay();
        push_replay();
        wait_q("b2b", 32);
        recovery_req_i = 1'b0;
        wait_q("b2b_second", 0);

        // async reset at cnt=10
        @(posedge clk);
        #1;
        recovery_req_i = 1'b1;
        req_cyc = cyc;
        push_replay();
        @(posedge clk);
        #1;
        recovery_req_i = 1'b0;
        wait_q("pre_reset", 23);
        q.delete();
        rst_ni = 1'b0;
        #1;
        chk("reset_mid_recover", 96'(recover_o), 96'(0));
        chk("reset_mid_we", 96'({rec_we_a_o, rec_we_b_o}), 96'(0));
        chk("reset_mid_busy", 96'(recovery_busy_o), 96'(0));
        for (int i = 0; i < 64; i++) m[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        start_replay("after_reset");

        repeat (3) @(posedge clk);
        chk("queue_drained", 96'(q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
